// File: rtl/cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// cpu_alu_seq
//   Sequential ALU for the CPU datapath. Takes one operation per valid/ready
//   handshake. Non-shift operations (and shifts by zero) complete at the accept
//   edge. Shifts run serially, one bit per cycle. Each completion writes a
//   registered result and a flag word {carry, zero, equal, larger}.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   i_valid        request valid
//   o_ready        ready to accept a request (high in IDLE)
//   i_opcode       ADD, SHL, SHR, CPR, AND, OR, XOR, NOT
//   i_carry_in_en  ADD only: also add the stored carry flag (ADC)
//   i_a, i_b       operands
//   i_shamt        shift amount, clamped to pDATA_WIDTH
//   i_flag_clr     clear the flag register at the next edge
//   o_valid        one-cycle completion pulse
//   o_result       registered result, held until the next completion
//   o_flags        registered {carry, zero, equal, larger}, held
// -----------------------------------------------------------------------------
module cpu_alu_seq #(
    parameter int pDATA_WIDTH  = 8,
    parameter int pSHAMT_WIDTH = $clog2(pDATA_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [2:0]              i_opcode,
    input  logic                    i_carry_in_en,
    input  logic [pDATA_WIDTH-1:0]  i_a,
    input  logic [pDATA_WIDTH-1:0]  i_b,
    input  logic [pSHAMT_WIDTH-1:0] i_shamt,
    input  logic                    i_flag_clr,
    output logic                    o_valid,
    output logic [pDATA_WIDTH-1:0]  o_result,
    output logic [3:0]              o_flags
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SHL = 3'd1,
        OP_SHR = 3'd2,
        OP_CPR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOT = 3'd7
    } enum_alu_opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic equal;
        logic larger;
    } struct_alu_flag_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [pSHAMT_WIDTH-1:0] SHAMT_MAX = pSHAMT_WIDTH'(pDATA_WIDTH);
    localparam logic [pSHAMT_WIDTH-1:0] CNT_ONE   = pSHAMT_WIDTH'(1);

    // Registered state
    state_t                  state_q,  state_d;
    logic [pDATA_WIDTH-1:0]  work_q,   work_d;
    logic [pSHAMT_WIDTH-1:0] cnt_q,    cnt_d;
    logic [pDATA_WIDTH-1:0]  a_q,      a_d;
    logic [pDATA_WIDTH-1:0]  b_q,      b_d;
    logic                    shl_q,    shl_d;
    logic [pDATA_WIDTH-1:0]  result_q, result_d;
    struct_alu_flag_t        flags_q,  flags_d;
    logic                    valid_q,  valid_d;

    // Combinational helpers
    enum_alu_opcode_t        op;
    logic                    accept;
    logic                    is_shift;
    logic [pSHAMT_WIDTH-1:0] shamt_eff;
    logic [pDATA_WIDTH:0]    sum;
    logic [pDATA_WIDTH-1:0]  shifted;
    logic                    shift_out_bit;

    // Completion bundle: whichever path finishes an op fills these in, and a
    // single write-back below turns them into result/flags.
    logic                    fin;
    logic [pDATA_WIDTH-1:0]  fin_result;
    logic                    fin_carry;
    logic [pDATA_WIDTH-1:0]  fin_a;
    logic [pDATA_WIDTH-1:0]  fin_b;

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        shl_d    = shl_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = 1'b0;

        fin        = 1'b0;
        fin_result = '0;
        fin_carry  = 1'b0;
        fin_a      = i_a;
        fin_b      = i_b;

        op        = enum_alu_opcode_t'(i_opcode);
        accept    = i_valid && (state_q == ST_IDLE);
        is_shift  = (op == OP_SHL) || (op == OP_SHR);
        shamt_eff = (i_shamt > SHAMT_MAX) ? SHAMT_MAX : i_shamt;

        // ADC uses the carry flag as it sits in the register at the accept edge.
        sum = {1'b0, i_a} + {1'b0, i_b}
            + (pDATA_WIDTH + 1)'(i_carry_in_en & flags_q.carry);

        // One-bit step of the serial shifter, zero fill.
        shifted       = shl_q ? {work_q[pDATA_WIDTH-2:0], 1'b0}
                              : {1'b0, work_q[pDATA_WIDTH-1:1]};
        shift_out_bit = shl_q ? work_q[pDATA_WIDTH-1] : work_q[0];

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt_eff != '0)) begin
                        state_d = ST_SHIFT;
                        work_d  = i_a;
                        cnt_d   = shamt_eff;
                        a_d     = i_a;
                        b_d     = i_b;
                        shl_d   = (op == OP_SHL);
                    end else begin
                        fin = 1'b1;
                        case (op)
                            OP_ADD: begin
                                fin_result = sum[pDATA_WIDTH-1:0];
                                fin_carry  = sum[pDATA_WIDTH];
                            end
                            OP_SHL,
                            OP_SHR:  fin_result = i_a;   // k = 0
                            OP_CPR:  fin_result = i_a;
                            OP_AND:  fin_result = i_a & i_b;
                            OP_OR:   fin_result = i_a | i_b;
                            OP_XOR:  fin_result = i_a ^ i_b;
                            OP_NOT:  fin_result = ~i_a;
                            default: fin_result = '0;
                        endcase
                    end
                end
            end

            ST_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = ST_IDLE;
                    fin        = 1'b1;
                    fin_result = shifted;
                    fin_carry  = shift_out_bit;
                    fin_a      = a_q;
                    fin_b      = b_q;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            valid_d        = 1'b1;
            result_d       = fin_result;
            flags_d.carry  = fin_carry;
            flags_d.zero   = (fin_result == '0);
            flags_d.equal  = (fin_a == fin_b);
            flags_d.larger = (fin_a > fin_b);
        end

        // Clear beats a coinciding completion for the flags only.
        if (i_flag_clr) begin
            flags_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shl_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shl_q    <= shl_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_flags  = flags_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_alu_seq
//   Directed bench for cpu_alu_seq (8-bit). Inputs change 1 ns after the
//   rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_cpu_alu_seq;

    localparam int W = 8;
    localparam int S = 4;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SHL = 3'd1;
    localparam logic [2:0] SHR = 3'd2;
    localparam logic [2:0] CPR = 3'd3;
    localparam logic [2:0] AND = 3'd4;
    localparam logic [2:0] XOR = 3'd6;
    localparam logic [2:0] NOT = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_opcode;
    logic         i_carry_in_en;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [S-1:0] i_shamt;
    logic         i_flag_clr;
    logic         o_valid;
    logic [W-1:0] o_result;
    logic [3:0]   o_flags;

    int checks = 0;
    int errors = 0;
    int low_cnt;

    cpu_alu_seq #(.pDATA_WIDTH(W), .pSHAMT_WIDTH(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_opcode      (i_opcode),
        .i_carry_in_en (i_carry_in_en),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_shamt       (i_shamt),
        .i_flag_clr    (i_flag_clr),
        .o_valid       (o_valid),
        .o_result      (o_result),
        .o_flags       (o_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [S-1:0] sh, input logic cin);
        i_valid       = 1'b1;
        i_opcode      = op;
        i_a           = a;
        i_b           = b;
        i_shamt       = sh;
        i_carry_in_en = cin;
        $display("txn op=%0d a=%02h b=%02h shamt=%0d cin=%0b", op, a, b, sh, cin);
    endtask

    // Flags are {carry, zero, equal, larger}.
    task automatic chk_done(input string tag, input logic [W-1:0] res, input logic [3:0] flg);
        chk({tag, "_valid"},  {31'd0, o_valid}, 32'd1);
        chk({tag, "_result"}, {24'd0, o_result}, {24'd0, res});
        chk({tag, "_flags"},  {28'd0, o_flags},  {28'd0, flg});
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_opcode = ADD; i_carry_in_en = 1'b0;
        i_a = '0; i_b = '0; i_shamt = '0; i_flag_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready",  {31'd0, o_ready},  32'd1);
        chk("rst_valid",  {31'd0, o_valid},  32'd0);
        chk("rst_result", {24'd0, o_result}, 32'd0);
        chk("rst_flags",  {28'd0, o_flags},  32'd0);

        // ADD 0xF0 + 0x20 = 0x110 -> 0x10, carry, larger
        req(ADD, 8'hF0, 8'h20, 4'd0, 1'b0); tick();
        chk_done("add1", 8'h10, 4'b1001);

        // ADC 0x01 + 0xFE + 1 = 0x100 -> 0x00, carry, zero
        req(ADD, 8'h01, 8'hFE, 4'd0, 1'b1); tick();
        chk_done("adc1", 8'h00, 4'b1100);

        // Flag clear, then ADC sees carry = 0
        i_valid = 1'b0; i_flag_clr = 1'b1; tick();
        i_flag_clr = 1'b0;
        $display("txn flag_clr");
        chk("clr_flags",  {28'd0, o_flags},  32'd0);
        chk("clr_valid",  {31'd0, o_valid},  32'd0);
        chk("clr_result", {24'd0, o_result}, 32'd0);
        req(ADD, 8'h01, 8'hFE, 4'd0, 1'b1); tick();
        chk_done("adc2", 8'hFF, 4'b0000);

        // SHR 0x06 by 2, ignored request during the busy cycles
        req(SHR, 8'h06, 8'h00, 4'd2, 1'b0); tick();
        chk("shr_ready_n1", {31'd0, o_ready}, 32'd0);
        chk("shr_valid_n1", {31'd0, o_valid}, 32'd0);
        req(ADD, 8'h55, 8'h55, 4'd0, 1'b0); tick();
        chk("shr_ready_n2", {31'd0, o_ready}, 32'd0);
        tick();
        i_valid = 1'b0;
        chk_done("shr", 8'h01, 4'b1001);
        chk("shr_ready_n3", {31'd0, o_ready}, 32'd1);
        tick();
        chk("shr_no_extra_valid", {31'd0, o_valid},  32'd0);
        chk("shr_result_held",    {24'd0, o_result}, 32'd1);

        // SHL 0xFF by 12, clamped to 8
        req(SHL, 8'hFF, 8'h00, 4'd12, 1'b0); tick();
        i_valid = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_ready == 1'b0 && o_valid == 1'b0) low_cnt++;
            tick();
        end
        chk("shl12_busy_cycles", low_cnt, 32'd8);
        chk_done("shl12", 8'h00, 4'b1101);

        // SHL by 0: immediate, result = a, carry = 0
        req(SHL, 8'h5A, 8'h5A, 4'd0, 1'b0); tick();
        chk_done("shl0", 8'h5A, 4'b0010);

        // Back-to-back single-cycle ops
        req(AND, 8'hCC, 8'hAA, 4'd0, 1'b0); tick();
        chk_done("and", 8'h88, 4'b0001);
        req(XOR, 8'hCC, 8'hAA, 4'd0, 1'b0); tick();
        chk_done("xor", 8'h66, 4'b0001);
        req(NOT, 8'h0F, 8'h00, 4'd0, 1'b0); tick();
        chk_done("not", 8'hF0, 4'b0001);
        req(CPR, 8'h33, 8'h33, 4'd0, 1'b0); tick();
        chk_done("cpr", 8'h33, 4'b0010);

        // Reset in the middle of SHL 0x01 by 5
        req(SHL, 8'h01, 8'h00, 4'd5, 1'b0); tick();
        i_valid = 1'b0;
        tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        $display("txn reset mid-shift");
        chk("abort_valid",  {31'd0, o_valid},  32'd0);
        chk("abort_result", {24'd0, o_result}, 32'd0);
        chk("abort_flags",  {28'd0, o_flags},  32'd0);
        chk("abort_ready",  {31'd0, o_ready},  32'd1);
        low_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_valid == 1'b1) low_cnt++;
        end
        chk("abort_no_late_valid", low_cnt, 32'd0);

        req(ADD, 8'h02, 8'h03, 4'd0, 1'b0); tick();
        i_valid = 1'b0;
        chk_done("add_after_rst", 8'h05, 4'b0000);
        tick();
        chk("valid_one_pulse", {31'd0, o_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
